// File: rtl/sddr_read_capture.sv
// sddr_read_capture: after a READ issue, waits the CAS latency, then gathers two-word DQ beats
// into one burst word. The sticky overrun flag is only built when SDDR_RDCAP_OVERRUN_EN is defined.
module sddr_read_capture #(
  parameter int DATA_BITS    = 16,
  parameter int BURST_LENGTH = 8
) (
  input  logic                              cpu_clock_i,
  input  logic                              reset_n_i,
  input  logic                              read_issue_i,
  input  logic [15:0]                       cas_latency_i,
  input  logic [DATA_BITS-1:0]              ddr3_dq_i [1:0],
  output logic                              data_rsp_ready_o,
  output logic [BURST_LENGTH*DATA_BITS-1:0] data_rsp_data_o,
  output logic                              busy_o,
  output logic                              overrun_o
);

  localparam int BEATS     = BURST_LENGTH / 2;
  localparam int BEAT_BITS = $clog2(BEATS) + 1;
  localparam int PAIR_BITS = 2 * DATA_BITS;
  localparam int WORD_BITS = BURST_LENGTH * DATA_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [15:0]          wait_cnt;
  logic [15:0]          wait_init;
  logic [BEAT_BITS-1:0] beat_cnt;
  logic [BEAT_BITS-1:0] beat_idx;
  logic                 capture;
  logic                 last_beat;
  logic [WORD_BITS-1:0] shadow;
  logic [WORD_BITS-1:0] assembled;

  // A latency of zero behaves exactly like a latency of one.
  always_comb begin
    if (cas_latency_i == 16'd0) begin
      wait_init = 16'd0;
    end else begin
      wait_init = cas_latency_i - 16'd1;
    end
  end

  always_comb begin
    capture  = 1'b0;
    beat_idx = beat_cnt;
    case (state)
      WAIT: begin
        capture  = (wait_cnt == 16'd0);
        beat_idx = {BEAT_BITS{1'b0}};
      end
      CAPTURE: begin
        capture  = 1'b1;
        beat_idx = beat_cnt;
      end
      default: begin
        capture  = 1'b0;
        beat_idx = beat_cnt;
      end
    endcase
    last_beat = capture && (beat_idx == LAST_BEAT);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (read_issue_i) begin
          next_state = WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (last_beat) begin
          next_state = IDLE;
        end else if (capture) begin
          next_state = CAPTURE;
        end else begin
          next_state = WAIT;
        end
      end
      CAPTURE: begin
        if (last_beat) begin
          next_state = IDLE;
        end else begin
          next_state = CAPTURE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Merge the current beat into the shadow so the final word can be published in the same edge.
  always_comb begin
    assembled = shadow;
    for (int k = 0; k < BEATS; k++) begin
      if (capture && (beat_idx == BEAT_BITS'(k))) begin
        assembled[k*PAIR_BITS +: PAIR_BITS] = {ddr3_dq_i[1], ddr3_dq_i[0]};
      end else begin
        assembled[k*PAIR_BITS +: PAIR_BITS] = shadow[k*PAIR_BITS +: PAIR_BITS];
      end
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (!reset_n_i) begin
      state            <= IDLE;
      busy_o           <= 1'b0;
      data_rsp_ready_o <= 1'b0;
      data_rsp_data_o  <= {WORD_BITS{1'b0}};
      shadow           <= {WORD_BITS{1'b0}};
      wait_cnt         <= 16'd0;
      beat_cnt         <= {BEAT_BITS{1'b0}};
    end else begin
      state            <= next_state;
      busy_o           <= (next_state != IDLE);
      data_rsp_ready_o <= last_beat;
      shadow           <= assembled;
      if (last_beat) begin
        data_rsp_data_o <= assembled;
      end
      case (state)
        IDLE: begin
          if (read_issue_i) begin
            wait_cnt <= wait_init;
            beat_cnt <= {BEAT_BITS{1'b0}};
          end
        end
        WAIT: begin
          if (wait_cnt != 16'd0) begin
            wait_cnt <= wait_cnt - 16'd1;
          end else if (!last_beat) begin
            beat_cnt <= BEAT_BITS'(1);
          end
        end
        CAPTURE: begin
          if (!last_beat) begin
            beat_cnt <= beat_idx + BEAT_BITS'(1);
          end
        end
        default: begin
          wait_cnt <= 16'd0;
          beat_cnt <= {BEAT_BITS{1'b0}};
        end
      endcase
    end
  end

`ifdef SDDR_RDCAP_OVERRUN_EN
  // Sticky: an issue arriving while a read is in flight.
  always_ff @(posedge cpu_clock_i) begin
    if (!reset_n_i) begin
      overrun_o <= 1'b0;
    end else if (read_issue_i && (state != IDLE)) begin
      overrun_o <= 1'b1;
    end
  end
`else
  assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_sddr_read_capture.sv
// Randomized and directed bench for sddr_read_capture against a cycle-indexed behavioural model.
module tb_sddr_read_capture;
  localparam int DB    = 16;
  localparam int BL    = 8;
  localparam int BEATS = BL / 2;
  localparam int W     = BL * DB;
`ifdef SDDR_RDCAP_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif
  localparam logic [W-1:0] PAT = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          issue = 1'b0;
  logic [15:0]   cl = 16'd0;
  logic [DB-1:0] dq [1:0];
  logic          ready;
  logic [W-1:0]  data;
  logic          busy;
  logic          ovr;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  sddr_read_capture #(.DATA_BITS(DB), .BURST_LENGTH(BL)) dut (
    .cpu_clock_i      (clk),
    .reset_n_i        (reset_n),
    .read_issue_i     (issue),
    .cas_latency_i    (cl),
    .ddr3_dq_i        (dq),
    .data_rsp_ready_o (ready),
    .data_rsp_data_o  (data),
    .busy_o           (busy),
    .overrun_o        (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Behavioural model: one in-flight read described by its issue cycle and effective latency.
  bit             mvalid = 1'b0;
  bit             m_act = 1'b0;
  int             m_t = 0;
  int             m_cl = 1;
  logic           m_ovr = 1'b0;
  logic [DB-1:0]  burst [BL];
  logic [W-1:0]   exp_data = '0;
  logic           exp_ready;
  logic           exp_busy;

  always @(negedge clk) begin
    exp_busy  = m_act && (cyc >= m_t + 1) && (cyc <= m_t + m_cl + BEATS - 1);
    exp_ready = m_act && (cyc == m_t + m_cl + BEATS);
    if (mvalid) begin
      if (exp_ready) begin
        for (int n = 0; n < BL; n++) exp_data[n*DB +: DB] = burst[n];
      end
      check("ready", W'(ready), W'(exp_ready));
      check("busy", W'(busy), W'(exp_busy));
      check("overrun", W'(ovr), W'(m_ovr));
      check("data", data, exp_data);
    end
    if (!reset_n) begin
      mvalid   = 1'b1;
      m_act    = 1'b0;
      m_ovr    = 1'b0;
      exp_data = '0;
    end else if (mvalid) begin
      if (m_act && (cyc >= m_t + m_cl) && (cyc < m_t + m_cl + BEATS)) begin
        burst[2*(cyc - m_t - m_cl)]     = dq[0];
        burst[2*(cyc - m_t - m_cl) + 1] = dq[1];
      end
      if (issue) begin
        if (exp_busy) begin
          m_ovr = m_ovr | OVR_EN;
        end else begin
          m_act = 1'b1;
          m_t   = cyc;
          m_cl  = (cl == 16'd0) ? 1 : int'(cl);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dq[0] = 16'($urandom);
    dq[1] = 16'($urandom);
  endtask

  // Issue in the current cycle, optionally check ready in that cycle, then run to the expected
  // ready cycle (off cycles after issue) and return in it, before its sampling edge.
  task automatic start_read(input logic [15:0] l, input int off, input bit pat,
                            input bit chk_now, input string name);
    int early;
    int lat;
    lat   = (l == 16'd0) ? 1 : int'(l);
    issue = 1'b1;
    cl    = l;
    @(negedge clk);
    if (chk_now) check({name, " ready at issue"}, W'(ready), W'(1'b1));
    step();
    issue = 1'b0;
    early = 0;
    for (int i = 1; i < off; i++) begin
      if (pat && i >= lat) begin
        dq[0] = 16'(2 * (i - lat) + 1);
        dq[1] = 16'(2 * (i - lat) + 2);
      end
      @(negedge clk);
      if (ready === 1'b1) early = 1;
      step();
    end
    check({name, " early ready"}, W'(early), W'(0));
  endtask

  task automatic expect_ready(input string name);
    @(negedge clk);
    check({name, " ready"}, W'(ready), W'(1'b1));
  endtask

  initial begin
    int cnt;
    dq[0] = 16'd0;
    dq[1] = 16'd0;
    repeat (3) step();
    @(negedge clk);
    check("reset data", data, W'(0));
    check("reset busy", W'(busy), W'(0));
    check("reset ready", W'(ready), W'(0));
    check("reset overrun", W'(ovr), W'(0));
    reset_n = 1'b1;
    step();
    step();

    start_read(16'd5, 9, 1'b1, 1'b0, "cl5");
    expect_ready("cl5");
    check("cl5 data", data, PAT);
    step();
    start_read(16'd0, 5, 1'b1, 1'b0, "cl0");
    expect_ready("cl0");
    check("cl0 data", data, PAT);
    step();
    start_read(16'd1, 5, 1'b1, 1'b0, "cl1");
    expect_ready("cl1");
    check("cl1 data", data, PAT);
    step();

    start_read(16'd2, 6, 1'b0, 1'b0, "b2b first");
    start_read(16'd3, 7, 1'b0, 1'b1, "b2b second");
    expect_ready("b2b second");
    step();

    issue = 1'b1;
    cl    = 16'd6;
    step();
    issue = 1'b0;
    step();
    step();
    issue = 1'b1;
    cl    = 16'd2;
    step();
    issue = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready === 1'b1) cnt++;
      step();
    end
    check("overrun ready count", W'(cnt), W'(1));
    check("overrun flag", W'(ovr), W'(OVR_EN));

    issue = 1'b1;
    cl    = 16'd3;
    step();
    issue = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("mid reset data", data, W'(0));
    check("mid reset busy", W'(busy), W'(0));
    check("mid reset overrun", W'(ovr), W'(0));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready === 1'b1) cnt++;
      step();
      @(negedge clk);
    end
    check("mid reset ready count", W'(cnt), W'(0));
    step();
    start_read(16'd2, 6, 1'b1, 1'b0, "after reset");
    expect_ready("after reset");
    check("after reset data", data, PAT);
    step();

    for (int i = 0; i < 1500; i++) begin
      issue   = ($urandom_range(0, 3) == 0);
      cl      = 16'($urandom_range(0, 8));
      reset_n = ($urandom_range(0, 249) != 0);
      step();
    end
    issue   = 1'b0;
    reset_n = 1'b1;
    repeat (20) step();

    start_read(16'hFFFF, 65539, 1'b0, 1'b0, "cl max");
    expect_ready("cl max");
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
